alu_op_sequencer: RTL and testbench

- Command-side controller that drives the 4-bit ALU slice: accepts 8-bit operation requests over a valid/ready handshake and sequences the slice over several cycles.
- Drives the slice's inA/inB/Cin/binv/less/op inputs and collects its result/Cout.
- Returns an 8-bit result with flags over a second valid/ready handshake.
- Sits between the instruction/control path and the ALU slice; the ALU slice is treated as combinational.

---
 rtl/alu_op_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Command-side sequencer for a 4-bit combinational ALU slice: runs 8-bit AND/OR/ADD/SUB/SLT
// as two nibble passes and 4x4 unsigned MUL as four shift-add passes.
module alu_op_sequencer (
  input  logic       clock,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_cout,
  output logic       rsp_zero,
  output logic       rsp_err,
  output logic [3:0] alu_inA,
  output logic [3:0] alu_inB,
  output logic       alu_Cin,
  output logic       alu_binv,
  output logic       alu_less,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_Cout,
  output logic [2:0] dbg_state
);

  // Handshakes: a transfer happens on a rising clock edge where valid && ready are both high;
  // valid never waits on ready, and payload is held stable while valid is high and ready is low.

  typedef enum logic [2:0] {IDLE = 3'd0, LO = 3'd1, HI = 3'd2, MUL = 3'd3, DONE = 3'd4} state_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;

  state_t     state, state_nxt;
  logic [2:0] op_q;
  logic [7:0] a_q, b_q;
  logic [7:0] res_q;  // nibble results, SLT bit, or the MUL product register
  logic       carry_q, cout_q, err_q;
  logic [1:0] step_q;
  logic       accept, is_arith, is_sub, slt_v;
  logic [1:0] f;

  assign accept   = cmd_valid && cmd_ready;
  assign is_sub   = (op_q == OP_SUB) || (op_q == OP_SLT);
  assign is_arith = (op_q == OP_ADD) || is_sub;
  assign f        = (op_q == OP_AND) ? 2'b00 : (op_q == OP_OR) ? 2'b01 : 2'b10;
  // Signed overflow of a - b, judged on the high-nibble pass.
  assign slt_v    = (a_q[7] != b_q[7]) && (alu_result[3] != a_q[7]);

  assign rsp_data  = res_q;
  assign rsp_cout  = cout_q;
  assign rsp_err   = err_q;
  assign rsp_zero  = (state == DONE) && (res_q == 8'd0);
  assign alu_less  = 1'b0;
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_inA   = 4'd0;
    alu_inB   = 4'd0;
    alu_Cin   = 1'b0;
    alu_binv  = 1'b0;
    alu_op    = 3'd0;
    case (state)
      IDLE: begin
        cmd_ready = resetn;
        if (cmd_valid && resetn) begin
          if (cmd_op <= OP_SLT)     state_nxt = LO;
          else if (cmd_op == OP_MUL) state_nxt = MUL;
          else                       state_nxt = DONE;
        end
      end
      LO: begin
        alu_inA   = a_q[3:0];
        alu_inB   = b_q[3:0];
        alu_binv  = is_sub;
        alu_Cin   = is_sub;
        alu_op    = {1'b0, f};
        state_nxt = HI;
      end
      HI: begin
        alu_inA   = a_q[7:4];
        alu_inB   = b_q[7:4];
        alu_binv  = is_sub;
        alu_Cin   = is_arith && carry_q;
        alu_op    = {1'b0, f};
        state_nxt = DONE;
      end
      MUL: begin
        alu_inA = res_q[7:4];
        alu_inB = res_q[0] ? a_q[3:0] : 4'd0;
        alu_op  = 3'b010;
        if (step_q == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      op_q    <= 3'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      res_q   <= 8'd0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      step_q  <= 2'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          op_q    <= cmd_op;
          a_q     <= cmd_a;
          b_q     <= cmd_b;
          step_q  <= 2'd0;
          carry_q <= 1'b0;
          cout_q  <= 1'b0;
          err_q   <= (cmd_op > OP_MUL);
          res_q   <= (cmd_op == OP_MUL) ? {4'd0, cmd_b[3:0]} : 8'd0;
        end
        LO: begin
          res_q[3:0] <= alu_result;
          carry_q    <= alu_Cout;
        end
        HI: begin
          if (op_q == OP_SLT) res_q <= {7'd0, alu_result[3] ^ slt_v};
          else                res_q[7:4] <= alu_result;
          cout_q <= is_arith && alu_Cout;
        end
        MUL: begin
          res_q  <= {alu_Cout, alu_result, res_q[3:1]};
          step_q <= step_q + 2'd1;
        end
        DONE: if (rsp_ready) err_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: models the 4-bit ALU slice, checks results against an
// arithmetic reference of each 8-bit operation, plus latency, backpressure and reset.
module tb_alu_op_sequencer;

  logic       clock = 1'b0;
  logic       resetn;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_cout, rsp_zero, rsp_err;
  logic [3:0] alu_inA, alu_inB, alu_result;
  logic       alu_Cin, alu_binv, alu_less, alu_Cout;
  logic [2:0] alu_op, dbg_state;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];  // {err, cout, data}

  always #5 clock = ~clock;

  alu_op_sequencer dut (
    .clock(clock), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_cout(rsp_cout),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_Cin(alu_Cin), .alu_binv(alu_binv),
    .alu_less(alu_less), .alu_op(alu_op), .alu_result(alu_result), .alu_Cout(alu_Cout),
    .dbg_state(dbg_state)
  );

  // Combinational slice: AND / OR / ADD with optional B inversion and carry in.
  always_comb begin
    logic [3:0] bb;
    logic [4:0] sum;
    bb  = alu_binv ? ~alu_inB : alu_inB;
    sum = {1'b0, alu_inA} + {1'b0, bb} + {4'd0, alu_Cin};
    alu_Cout = sum[4];
    case (alu_op[1:0])
      2'b00:   alu_result = alu_inA & bb;
      2'b01:   alu_result = alu_inA | bb;
      2'b10:   alu_result = sum[3:0];
      default: alu_result = 4'd0;
    endcase
  end

  function automatic void ref_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] d, output logic c, output logic e,
                                    output int lat);
    logic [8:0] s;
    d = 8'd0; c = 1'b0; e = 1'b0; lat = 3;
    s = {1'b0, a} + {1'b0, ~b} + 9'd1;
    case (op)
      3'd0: d = a & b;
      3'd1: d = a | b;
      3'd2: begin s = {1'b0, a} + {1'b0, b}; d = s[7:0]; c = s[8]; end
      3'd3: begin d = s[7:0]; c = s[8]; end
      3'd4: begin d = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0; c = s[8]; end
      3'd5: begin d = 8'(a[3:0]) * 8'(b[3:0]); lat = 5; end
      default: begin e = 1'b1; lat = 1; end
    endcase
  endfunction

  // Entered and left #1 after a rising edge with the DUT idle.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int hold, input string tag);
    logic [7:0] d; logic c, e; int el, lat; logic [9:0] exp;
    ref_model(op, a, b, d, c, e, el);
    exp_q.push_back({e, c, d});
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1; rsp_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s cmd_ready got %b exp 1", tag, cmd_ready); end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      checks++;
      if (cmd_ready !== 1'b0 || alu_less !== 1'b0) begin
        errors++; $display("FAIL %s busy cmd_ready/less got %b%b exp 00", tag, cmd_ready, alu_less);
      end
      cmd_valid = 1'($urandom_range(0, 1)); cmd_op = 3'($urandom); cmd_a = 8'($urandom);
      @(posedge clock); #1; lat++;
    end
    exp = exp_q.pop_front();
    checks++;
    if (lat !== el) begin errors++; $display("FAIL %s latency got %0d exp %0d", tag, lat, el); end
    checks++;
    if (rsp_data !== exp[7:0]) begin errors++; $display("FAIL %s data got %h exp %h", tag, rsp_data, exp[7:0]); end
    checks++;
    if ({rsp_err, rsp_cout, rsp_zero} !== {exp[9], exp[8], exp[7:0] == 8'd0}) begin
      errors++; $display("FAIL %s err/cout/zero got %b%b%b exp %b%b%b", tag, rsp_err, rsp_cout, rsp_zero,
                         exp[9], exp[8], exp[7:0] == 8'd0);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      checks++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || {rsp_err, rsp_cout, rsp_data} !== exp) begin
        errors++; $display("FAIL %s hold v/rdy/data got %b%b %h exp 10 %h", tag, rsp_valid, cmd_ready,
                           {rsp_err, rsp_cout, rsp_data}, exp);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL %s after handshake v/rdy/err got %b%b%b exp 010", tag, rsp_valid, cmd_ready, rsp_err);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 8'd0; cmd_b = 8'd0; rsp_ready = 1'b0;
    #3;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_cout, rsp_zero, rsp_err} !== 13'd0) begin
      errors++; $display("FAIL reset rsp outputs got %b exp 0", {cmd_ready, rsp_valid, rsp_data, rsp_cout, rsp_zero, rsp_err});
    end
    checks++;
    if ({alu_inA, alu_inB, alu_Cin, alu_binv, alu_less, alu_op} !== 14'd0) begin
      errors++; $display("FAIL reset alu outputs got %h exp 0", {alu_inA, alu_inB, alu_Cin, alu_binv, alu_less, alu_op});
    end
    @(posedge clock); #2; resetn = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset release rdy/valid got %b%b exp 10", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_directed();
    logic [2:0] ops [14] = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd0, 3'd1, 3'd5, 3'd5, 3'd5, 3'd6, 3'd7};
    logic [7:0] as  [14] = '{8'h3A, 8'hFF, 8'h10, 8'h01, 8'h80, 8'h05, 8'h7F, 8'hF0, 8'hF0, 8'h0F, 8'h00, 8'h0F, 8'h12, 8'h34};
    logic [7:0] bs  [14] = '{8'h27, 8'h01, 8'h01, 8'h02, 8'h01, 8'hFB, 8'h80, 8'h3C, 8'h3C, 8'h0D, 8'h09, 8'h0F, 8'h56, 8'h78};
    for (int i = 0; i < 14; i++) run_cmd(ops[i], as[i], bs[i], 0, $sformatf("directed%0d", i));
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      run_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), $urandom_range(0, 3),
              $sformatf("random%0d", i));
  endtask

  task automatic test_back_to_back();
    int lat;
    cmd_op = 3'd2; cmd_a = 8'h3A; cmd_b = 8'h27; cmd_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clock); #1; cmd_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin @(posedge clock); #1; lat++; end
    checks++;
    if (lat !== 3 || rsp_data !== 8'h61) begin
      errors++; $display("FAIL b2b first lat/data got %0d %h exp 3 61", lat, rsp_data);
    end
    cmd_op = 3'd0; cmd_a = 8'hF0; cmd_b = 8'h3C; cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      checks++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_data !== 8'h61 || rsp_cout !== 1'b0 || rsp_zero !== 1'b0) begin
        errors++; $display("FAIL b2b stall v/rdy/data got %b%b %h exp 10 61", rsp_valid, cmd_ready, rsp_data);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1; rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL b2b handshake edge v/rdy got %b%b exp 01", rsp_valid, cmd_ready);
    end
    @(posedge clock); #1; cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b second accept rdy got %b exp 0", cmd_ready); end
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin @(posedge clock); #1; lat++; end
    checks++;
    if (lat !== 3 || rsp_data !== 8'h30) begin
      errors++; $display("FAIL b2b second lat/data got %0d %h exp 3 30", lat, rsp_data);
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1; rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    cmd_op = 3'd5; cmd_a = 8'h0F; cmd_b = 8'h0D; cmd_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clock); #1; cmd_valid = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    #2; resetn = 1'b0; #1;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_cout, rsp_zero, rsp_err,
         alu_inA, alu_inB, alu_Cin, alu_binv, alu_less, alu_op} !== 27'd0) begin
      errors++; $display("FAIL midreset outputs got %h exp 0", {cmd_ready, rsp_valid, rsp_data, rsp_cout, rsp_zero,
                         rsp_err, alu_inA, alu_inB, alu_Cin, alu_binv, alu_less, alu_op});
    end
    #3; resetn = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midreset release rdy got %b exp 1", cmd_ready); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset stale rsp_valid got %b exp 0", rsp_valid); end
      @(posedge clock); #1;
    end
    rsp_ready = 1'b0;
    run_cmd(3'd2, 8'h01, 8'h01, 0, "post_reset_add");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
